// File: rtl/alu_cmd_sequencer.sv
// Command-side master for alu_output_unit: buffers host commands, issues them to the ALU one at a time,
// waits a settle window, captures Y/flags and returns them in order. Optional accumulator: ALU_ACC_EN.
module alu_cmd_sequencer #(
    parameter int DATA_W        = 8,
    parameter int FLAG_W        = 4,
    parameter int CMD_DEPTH     = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_y,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              rsp_err,
    output logic              busy
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [CNT_W-1:0]   r_settleCnt;
    logic               r_curErr;

    logic [3:0]         r_fifoOp [CMD_DEPTH];
    logic [DATA_W-1:0]  r_fifoA  [CMD_DEPTH];
    logic [DATA_W-1:0]  r_fifoB  [CMD_DEPTH];
    logic [PTR_W:0]     r_wrPtr;
    logic [PTR_W:0]     r_rdPtr;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_capture;
    logic               w_headLegal;
    logic [3:0]         w_headOp;
    logic [DATA_W-1:0]  w_headA;
    logic [DATA_W-1:0]  w_headB;
    logic [DATA_W-1:0]  w_issueA;

    function automatic logic isLegalOp(input logic [3:0] op);
        case (op)
            4'b1110, 4'b1111, 4'b1100, 4'b1000, 4'b1001,
            4'b1010, 4'b1011, 4'b0001, 4'b0000: isLegalOp = 1'b1;
            default:                            isLegalOp = 1'b0;
        endcase
    endfunction

    assign w_empty     = (r_wrPtr == r_rdPtr);
    assign w_full      = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                         (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
    assign cmd_ready   = !w_full;
    assign w_push      = cmd_valid && !w_full;
    assign busy        = (r_state != S_IDLE) || !w_empty;

    assign w_headOp    = r_fifoOp[r_rdPtr[PTR_W-1:0]];
    assign w_headA     = r_fifoA[r_rdPtr[PTR_W-1:0]];
    assign w_headB     = r_fifoB[r_rdPtr[PTR_W-1:0]];
    assign w_headLegal = isLegalOp(w_headOp);

`ifdef ALU_ACC_EN
    logic               r_fifoAcc [CMD_DEPTH];
    logic [DATA_W-1:0]  r_acc;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoAcc[r_wrPtr[PTR_W-1:0]] <= cmd_use_acc;
        end
    end

    // Only legal results feed the accumulator; illegal commands leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_capture && !r_curErr) begin
            r_acc <= alu_y;
        end
    end

    assign w_issueA = r_fifoAcc[r_rdPtr[PTR_W-1:0]] ? r_acc : w_headA;
`else
    logic w_unusedUseAcc;
    assign w_unusedUseAcc = cmd_use_acc;
    assign w_issueA       = w_headA;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoOp[r_wrPtr[PTR_W-1:0]] <= cmd_opcode;
            r_fifoA[r_wrPtr[PTR_W-1:0]]  <= cmd_a;
            r_fifoB[r_wrPtr[PTR_W-1:0]]  <= cmd_b;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_stateNext = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settleCnt == '0) begin
                    w_capture   = 1'b1;
                    w_stateNext = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_stateNext = S_SETTLE;
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // An illegal command still walks through SETTLE so its response timing matches a legal one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_settleCnt <= '0;
            r_curErr    <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            rsp_valid   <= 1'b0;
            rsp_y       <= '0;
            rsp_flags   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr     <= r_rdPtr + 1'b1;
                r_settleCnt <= SETTLE_LOAD;
                r_curErr    <= !w_headLegal;
                if (w_headLegal) begin
                    alu_a      <= w_issueA;
                    alu_b      <= w_headB;
                    alu_opcode <= w_headOp;
                end
            end else if (r_state == S_SETTLE && r_settleCnt != '0) begin
                r_settleCnt <= r_settleCnt - CNT_W'(1);
            end
            if (w_capture) begin
                rsp_valid <= 1'b1;
                rsp_y     <= r_curErr ? '0 : alu_y;
                rsp_flags <= r_curErr ? '0 : alu_flags;
                rsp_err   <= r_curErr;
            end else if (r_state == S_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a small behavioural ALU on the alu_* side.
// Expected accumulator results depend on ALU_ACC_EN.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_opcode = '0;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic       cmd_use_acc = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_y;
    logic [3:0] alu_flags;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_y;
    logic [3:0] rsp_flags;
    logic       rsp_err;
    logic       busy;

    typedef struct packed {
        logic [7:0] y;
        logic [3:0] flags;
        logic       err;
    } rsp_t;

    rsp_t expQ[$];
    int   testsRun = 0;
    int   testsFailed = 0;
    int   rspSeen = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DATA_W(8), .FLAG_W(4), .CMD_DEPTH(4), .SETTLE_CYCLES(1)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_y(alu_y), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy)
    );

    // Flags are {negative, zero, carry/borrow, 0}.
    always_comb begin
        logic [8:0]  wide;
        logic [15:0] prod;
        logic        carry;
        wide  = '0;
        prod  = '0;
        carry = 1'b0;
        case (alu_opcode)
            4'b1110: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; carry = wide[8]; end
            4'b1111: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; carry = wide[8]; end
            4'b1100: begin prod = alu_a * alu_b; wide = {1'b0, prod[7:0]}; carry = |prod[15:8]; end
            4'b1000: wide = {1'b0, ~alu_a};
            4'b1001: wide = {1'b0, alu_a ^ alu_b};
            4'b1010: wide = {1'b0, alu_a | alu_b};
            4'b1011: wide = {1'b0, alu_a & alu_b};
            4'b0001: begin wide = {1'b0, alu_a[6:0], 1'b0}; carry = alu_a[7]; end
            4'b0000: begin wide = {2'b00, alu_a[7:1]}; carry = alu_a[0]; end
            default: wide = '0;
        endcase
        alu_y     = wide[7:0];
        alu_flags = {wide[7], wide[7:0] == 8'h00, carry, 1'b0};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic useAcc, input logic [7:0] expY,
                                 input logic [3:0] expFlags, input logic expErr);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        cmd_opcode  = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = useAcc;
        cmd_valid   = 1'b1;
        while (!cmd_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!cmd_ready) begin
            checkOutput("cmdAcceptTimeout", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            expQ.push_back('{y: expY, flags: expFlags, err: expErr});
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic setRspReady(input logic v);
        @(posedge clk);
        #1 rsp_ready = v;
    endtask

    task automatic waitDrain();
        int cyc;
        cyc = 0;
        while ((expQ.size() != 0 || busy || rsp_valid) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("drainTimeout", {31'd0, (cyc >= 300)}, 32'd0);
    endtask

    // Monitor: while a response is held it must already equal the head of the queue.
    always @(negedge clk) begin
        rsp_t exp;
        if (!rst && rsp_valid) begin
            if (expQ.size() == 0) begin
                if (rsp_ready) begin
                    rspSeen++;
                    checkOutput("unexpectedRsp", {31'd0, rsp_valid}, 32'd0);
                end
            end else begin
                exp = expQ[0];
                checkOutput(rsp_ready ? "rspY" : "heldRspY", {24'd0, rsp_y}, {24'd0, exp.y});
                checkOutput(rsp_ready ? "rspFlags" : "heldRspFlags", {28'd0, rsp_flags}, {28'd0, exp.flags});
                checkOutput(rsp_ready ? "rspErr" : "heldRspErr", {31'd0, rsp_err}, {31'd0, exp.err});
                if (rsp_ready) begin
                    void'(expQ.pop_front());
                    rspSeen++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] expAccY;

        // Reset held with a command offered: nothing may be queued.
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_opcode = 4'b1110;
        cmd_a = 8'd1;
        cmd_b = 8'd1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("resetCmdReady", {31'd0, cmd_ready}, 32'd1);
        checkOutput("resetRspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetAluA", {24'd0, alu_a}, 32'd0);
        checkOutput("resetAluB", {24'd0, alu_b}, 32'd0);
        checkOutput("resetAluOp", {28'd0, alu_opcode}, 32'd0);
        @(negedge clk);
        checkOutput("noPushDuringReset", {31'd0, busy}, 32'd0);

        // Single command latency: response visible two edges after the handshake.
        setRspReady(1'b1);
        applyStimulus(4'b1111, 8'd75, 8'd75, 1'b0, 8'h00, 4'b0100, 1'b0);
        @(negedge clk);
        checkOutput("latencyEdge1", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        checkOutput("latencyEdge2", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        checkOutput("latencyEdge3", {31'd0, rsp_valid}, 32'd1);
        waitDrain();

        // Back-pressure: one in flight plus four queued fills the sequencer.
        setRspReady(1'b0);
        applyStimulus(4'b1110, 8'd75, 8'd31, 1'b0, 8'd106, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 8'd75, 8'd31, 1'b0, 8'd44, 4'b0000, 1'b0);
        applyStimulus(4'b1011, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000, 1'b0);
        applyStimulus(4'b1001, 8'hFF, 8'h0F, 1'b0, 8'hF0, 4'b1000, 1'b0);
        applyStimulus(4'b1100, 8'd3, 8'd5, 1'b0, 8'd15, 4'b0000, 1'b0);
        @(negedge clk);
        cmd_opcode = 4'b1010;
        cmd_a = 8'h0F;
        cmd_b = 8'hF0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("cmdReadyWhenFull", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        setRspReady(1'b1);
        applyStimulus(4'b1010, 8'h0F, 8'hF0, 1'b0, 8'hFF, 4'b1000, 1'b0);
        waitDrain();

        // Illegal opcode: error response and ALU inputs keep the previous command.
        applyStimulus(4'b0101, 8'd9, 8'd3, 1'b0, 8'h00, 4'b0000, 1'b1);
        waitDrain();
        checkOutput("illegalKeepsOp", {28'd0, alu_opcode}, 32'hA);
        checkOutput("illegalKeepsA", {24'd0, alu_a}, 32'h0F);
        checkOutput("illegalKeepsB", {24'd0, alu_b}, 32'hF0);
        applyStimulus(4'b1110, 8'd1, 8'd2, 1'b0, 8'd3, 4'b0000, 1'b0);
        waitDrain();

        // Reset while a response is pending and commands are queued.
        setRspReady(1'b0);
        applyStimulus(4'b1110, 8'd1, 8'd1, 1'b0, 8'd2, 4'b0000, 1'b0);
        applyStimulus(4'b1110, 8'd2, 8'd2, 1'b0, 8'd4, 4'b0000, 1'b0);
        applyStimulus(4'b1110, 8'd3, 8'd3, 1'b0, 8'd6, 4'b0000, 1'b0);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        checkOutput("rspBeforeMidReset", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        expQ.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midResetRspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
        checkOutput("midResetCmdReady", {31'd0, cmd_ready}, 32'd1);
        rspSeen = 0;
        setRspReady(1'b1);
        repeat (20) @(negedge clk);
        checkOutput("noRspAfterReset", rspSeen, 32'd0);

        // Accumulator operand selection.
`ifdef ALU_ACC_EN
        expAccY = 8'd35;
`else
        expAccY = 8'd119;
`endif
        applyStimulus(4'b1110, 8'd10, 8'd5, 1'b0, 8'd15, 4'b0000, 1'b0);
        applyStimulus(4'b1110, 8'd99, 8'd20, 1'b1, expAccY, 4'b0000, 1'b0);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
